// File: rtl/segre_wb_buffer.sv
// Write-back buffer between segre_mmu and main memory: queues and coalesces dirty lines,
// forwards buffered lines to line reads, and serialises reads/writes onto one memory port.
module segre_wb_buffer #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_rdy_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LINE_W-1:0] wr_data_i,
    output logic              wr_full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              mem_rd_req_o,
    output logic              mem_wr_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_rdy_i,
    input  logic [LINE_W-1:0] mem_data_i
);
    localparam int LA_W  = ADDR_W - OFF_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LA_W-1:0]   ent_la_q   [DEPTH];
    logic [LINE_W-1:0] ent_data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pend_q, pend_d;
    logic [LA_W-1:0]   pend_la_q, pend_la_d;
    logic              fwd_q, fwd_d;
    logic [LINE_W-1:0] fwd_data_q, fwd_data_d;
    logic              rd_rdy_q, rd_rdy_d;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic              mem_wr_req_q, mem_wr_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;

    logic [LA_W-1:0]   wr_la_s, rd_la_s;
    logic              co_hit_s;
    logic [PTR_W-1:0]  co_idx_s;
    logic              fw_hit_s;
    logic [LINE_W-1:0] fw_data_s;
    logic              deq_s, enq_s, drop_s, wr_acc_s;
    logic [CNT_W-1:0]  cnt_free_s;
    logic              wr_rd_same_s, rd_hit_s, wr_pend_match_s;
    logic [LINE_W-1:0] rd_hit_data_s;
    logic              unused_s;

    function automatic logic [LA_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFF_W];
    endfunction

    assign wr_la_s  = line_of(wr_addr_i);
    assign rd_la_s  = line_of(rd_addr_i);
    assign unused_s = ^{rd_addr_i[OFF_W-1:0], wr_addr_i[OFF_W-1:0]};

    // Scan oldest to youngest so the last match found is the youngest one.
    always_comb begin : search_p
        logic [PTR_W-1:0] idx_v;
        logic             valid_v, co_m_v, fw_m_v;
        idx_v     = {PTR_W{1'b0}};
        valid_v   = 1'b0;
        co_m_v    = 1'b0;
        fw_m_v    = 1'b0;
        co_hit_s  = 1'b0;
        co_idx_s  = {PTR_W{1'b0}};
        fw_hit_s  = 1'b0;
        fw_data_s = {LINE_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_v   = head_q + PTR_W'(i);
            valid_v = (CNT_W'(i) < count_q);
            // The head being written to memory must not change under the in-flight write.
            co_m_v  = wr_req_i && valid_v && (ent_la_q[idx_v] == wr_la_s) &&
                      !((state_q == ST_WR_WAIT) && (idx_v == head_q));
            fw_m_v  = valid_v && (ent_la_q[idx_v] == rd_la_s);
            co_hit_s  = co_hit_s | co_m_v;
            co_idx_s  = co_m_v ? idx_v : co_idx_s;
            fw_hit_s  = fw_hit_s | fw_m_v;
            fw_data_s = fw_m_v ? ent_data_q[idx_v] : fw_data_s;
        end
    end

    assign deq_s           = (state_q == ST_WR_WAIT) && mem_rdy_i;
    assign cnt_free_s      = count_q - {{PTR_W{1'b0}}, deq_s};
    assign enq_s           = wr_req_i && !co_hit_s && (cnt_free_s < FULL_CNT);
    assign drop_s          = wr_req_i && !co_hit_s && !(cnt_free_s < FULL_CNT);
    assign wr_acc_s        = co_hit_s || enq_s;
    assign wr_rd_same_s    = wr_acc_s && (wr_la_s == rd_la_s);
    assign rd_hit_s        = fw_hit_s || wr_rd_same_s;
    assign rd_hit_data_s   = wr_rd_same_s ? wr_data_i : fw_data_s;
    assign wr_pend_match_s = pend_q && wr_acc_s && (wr_la_s == pend_la_q);

    // Read bookkeeping and memory-port FSM next state.
    always_comb begin
        state_d      = state_q;
        mem_rd_req_d = 1'b0;
        mem_wr_req_d = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        rd_rdy_d     = 1'b0;
        rd_data_d    = rd_data_q;
        pend_d       = pend_q;
        pend_la_d    = pend_la_q;
        fwd_d        = fwd_q;
        fwd_data_d   = fwd_data_q;

        if (rd_req_i && rd_hit_s) begin
            rd_rdy_d  = 1'b1;
            rd_data_d = rd_hit_data_s;
        end else if (rd_req_i) begin
            pend_d    = 1'b1;
            pend_la_d = rd_la_s;
            fwd_d     = 1'b0;
        end else if (wr_pend_match_s && (state_q != ST_RD_WAIT)) begin
            // A waiting read (held back by a draining buffer) is satisfied by the new write.
            rd_rdy_d  = 1'b1;
            rd_data_d = wr_data_i;
            pend_d    = 1'b0;
        end else if (wr_pend_match_s) begin
            fwd_d      = 1'b1;
            fwd_data_d = wr_data_i;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_d && (count_q < RD_LIMIT)) begin
                    state_d      = ST_RD_WAIT;
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = {pend_la_d, {OFF_W{1'b0}}};
                end else if (count_q != CNT_ZERO) begin
                    state_d      = ST_WR_WAIT;
                    mem_wr_req_d = 1'b1;
                    mem_addr_d   = {ent_la_q[head_q], {OFF_W{1'b0}}};
                    mem_data_d   = (co_hit_s && (co_idx_s == head_q)) ? wr_data_i
                                                                      : ent_data_q[head_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rdy_i) begin
                    state_d   = ST_IDLE;
                    rd_rdy_d  = 1'b1;
                    rd_data_d = fwd_q ? fwd_data_q : (wr_pend_match_s ? wr_data_i : mem_data_i);
                    pend_d    = 1'b0;
                    fwd_d     = 1'b0;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (mem_rdy_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers and status flags.
    always_comb begin
        count_d    = count_q + {{PTR_W{1'b0}}, enq_s} - {{PTR_W{1'b0}}, deq_s};
        head_d     = head_q + {{(PTR_W-1){1'b0}}, deq_s};
        tail_d     = tail_q + {{(PTR_W-1){1'b0}}, enq_s};
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == CNT_ZERO) && (state_d != ST_WR_WAIT);
        overflow_d = overflow_q | drop_s;
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= ST_IDLE;
            head_q       <= {PTR_W{1'b0}};
            tail_q       <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            pend_q       <= 1'b0;
            pend_la_q    <= {LA_W{1'b0}};
            fwd_q        <= 1'b0;
            fwd_data_q   <= {LINE_W{1'b0}};
            rd_rdy_q     <= 1'b0;
            rd_data_q    <= {LINE_W{1'b0}};
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_data_q   <= {LINE_W{1'b0}};
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            pend_la_q    <= pend_la_d;
            fwd_q        <= fwd_d;
            fwd_data_q   <= fwd_data_d;
            rd_rdy_q     <= rd_rdy_d;
            rd_data_q    <= rd_data_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
        end
    end

    // Entry storage: new lines land at the tail, coalesced data overwrites in place.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_la_q[i]   <= {LA_W{1'b0}};
                ent_data_q[i] <= {LINE_W{1'b0}};
            end
        end else if (enq_s) begin
            ent_la_q[tail_q]   <= wr_la_s;
            ent_data_q[tail_q] <= wr_data_i;
        end else if (co_hit_s) begin
            ent_data_q[co_idx_s] <= wr_data_i;
        end
    end

    assign rd_rdy_o     = rd_rdy_q;
    assign rd_data_o    = rd_data_q;
    assign wr_full_o    = full_q;
    assign empty_o      = empty_q;
    assign overflow_o   = overflow_q;
    assign mem_rd_req_o = mem_rd_req_q;
    assign mem_wr_req_o = mem_wr_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_segre_wb_buffer.sv
// Directed bench for segre_wb_buffer with a behavioural single-outstanding memory.
module tb_segre_wb_buffer;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk_i = 1'b0;
    logic              rsn_i = 1'b0;
    logic              rd_req_i = 1'b0;
    logic [ADDR_W-1:0] rd_addr_i = '0;
    logic              rd_rdy_o;
    logic [LINE_W-1:0] rd_data_o;
    logic              wr_req_i = 1'b0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic [LINE_W-1:0] wr_data_i = '0;
    logic              wr_full_o, empty_o, overflow_o;
    logic              mem_rd_req_o, mem_wr_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_rdy_i;
    logic [LINE_W-1:0] mem_data_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mem_lat = 2;
    int n_mem_rd = 0;
    logic [LINE_W-1:0] mem_rd_val = '0;
    logic [ADDR_W-1:0] wlog_addr [$];
    logic [LINE_W-1:0] wlog_data [$];

    segre_wb_buffer dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_rdy_o(rd_rdy_o), .rd_data_o(rd_data_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_full_o(wr_full_o), .empty_o(empty_o), .overflow_o(overflow_o),
        .mem_rd_req_o(mem_rd_req_o), .mem_wr_req_o(mem_wr_req_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory: logs writes at request time, answers mem_lat cycles later, gives up on reset.
    initial begin : mem_model
        bit is_rd;
        bit aborted;
        mem_rdy_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_rdy_i = 1'b0;
            if (rsn_i && (mem_rd_req_o || mem_wr_req_o)) begin
                is_rd = mem_rd_req_o;
                if (is_rd) n_mem_rd++;
                else begin
                    wlog_addr.push_back(mem_addr_o);
                    wlog_data.push_back(mem_data_o);
                end
                aborted = 1'b0;
                for (int k = 0; k < mem_lat; k++) begin
                    @(posedge clk_i); #1;
                    if (!rsn_i) aborted = 1'b1;
                end
                if (!aborted && rsn_i) begin
                    mem_rdy_i  = 1'b1;
                    mem_data_i = is_rd ? mem_rd_val : {4{32'hDEAD_BEEF}};
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        wr_req_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic apply_reset();
        rsn_i = 1'b0;
        tick(); tick();
        rsn_i = 1'b1;
        tick();
    endtask

    task automatic clear_logs();
        wlog_addr.delete(); wlog_data.delete(); n_mem_rd = 0;
    endtask

    task automatic wait_empty(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (empty_o === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_rd_rdy(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (rd_rdy_o === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (rd_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_rd_rdy: got %0b want 0", rd_rdy_o); end
        checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", rd_data_o); end
        checks++; if (wr_full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b want 0", wr_full_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b want 1", empty_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b want 0", overflow_o); end
        checks++; if ({mem_rd_req_o, mem_wr_req_o} !== 2'b00) begin errors++; $display("FAIL rst_mem_req: got %b want 00", {mem_rd_req_o, mem_wr_req_o}); end
        checks++; if (mem_addr_o !== '0 || mem_data_o !== '0) begin errors++; $display("FAIL rst_mem_bus: got addr %h data %h want 0", mem_addr_o, mem_data_o); end
        rsn_i = 1'b1;
        tick();
        checks++; if (empty_o !== 1'b1 || mem_wr_req_o !== 1'b0) begin errors++; $display("FAIL rst_release: got empty %0b wr_req %0b want 1 0", empty_o, mem_wr_req_o); end
    endtask

    task automatic test_reset_mid_wr();
        bit seen_req;
        bit not_empty;
        clear_logs();
        mem_lat = 20;
        do_write(32'h0000_0500, {4{32'h5000_0001}});
        do_write(32'h0000_0510, {4{32'h5000_0002}});
        do_write(32'h0000_0520, {4{32'h5000_0003}});
        tick(); tick();
        checks++; if (empty_o !== 1'b0 || mem_addr_o !== 32'h0000_0500) begin errors++; $display("FAIL mid_pre: got empty %0b addr %h want 0 00000500", empty_o, mem_addr_o); end
        rsn_i = 1'b0;
        #1;
        checks++; if (mem_addr_o !== '0 || mem_data_o !== '0) begin errors++; $display("FAIL mid_bus: got addr %h data %h want 0", mem_addr_o, mem_data_o); end
        checks++; if (empty_o !== 1'b1 || wr_full_o !== 1'b0 || overflow_o !== 1'b0) begin errors++; $display("FAIL mid_flags: got empty %0b full %0b ovf %0b want 1 0 0", empty_o, wr_full_o, overflow_o); end
        tick(); tick();
        rsn_i = 1'b1;
        seen_req = 1'b0; not_empty = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (mem_rd_req_o || mem_wr_req_o) seen_req = 1'b1;
            if (empty_o !== 1'b1) not_empty = 1'b1;
        end
        checks++; if (seen_req !== 1'b0) begin errors++; $display("FAIL mid_no_req: got request %0b want 0", seen_req); end
        checks++; if (not_empty !== 1'b0) begin errors++; $display("FAIL mid_empty_hold: got nonempty %0b want 0", not_empty); end
        mem_lat = 2;
    endtask

    task automatic test_forward();
        bit ok;
        clear_logs();
        do_write(32'h0000_0100, {4{32'hA5A5_0100}});
        rd_req_i = 1'b1; rd_addr_i = 32'h0000_0104;
        tick();
        rd_req_i = 1'b0;
        checks++; if (rd_rdy_o !== 1'b1) begin errors++; $display("FAIL fwd_rdy: got %0b want 1", rd_rdy_o); end
        checks++; if (rd_data_o !== {4{32'hA5A5_0100}}) begin errors++; $display("FAIL fwd_data: got %h want %h", rd_data_o, {4{32'hA5A5_0100}}); end
        tick();
        checks++; if (rd_rdy_o !== 1'b0) begin errors++; $display("FAIL fwd_pulse: got %0b want 0", rd_rdy_o); end
        wait_empty(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd_drain: got empty %0b want 1", empty_o); end
        checks++; if (n_mem_rd !== 0) begin errors++; $display("FAIL fwd_no_memrd: got %0d reads want 0", n_mem_rd); end
        checks++; if (wlog_addr.size() != 1) begin errors++; $display("FAIL fwd_wr_count: got %0d writes want 1", wlog_addr.size()); end
    endtask

    task automatic test_coalesce();
        bit ok;
        clear_logs();
        do_write(32'h0000_0200, {4{32'hD100_0000}});
        do_write(32'h0000_0208, {4{32'hD200_0000}});
        checks++; if (mem_wr_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0200) begin errors++; $display("FAIL co_req: got req %0b addr %h want 1 00000200", mem_wr_req_o, mem_addr_o); end
        checks++; if (mem_data_o !== {4{32'hD200_0000}}) begin errors++; $display("FAIL co_data: got %h want %h", mem_data_o, {4{32'hD200_0000}}); end
        wait_empty(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL co_drain: got empty %0b want 1", empty_o); end
        checks++; if (wlog_addr.size() != 1) begin errors++; $display("FAIL co_wr_count: got %0d writes want 1", wlog_addr.size()); end
        if (wlog_data.size() > 0) begin
            checks++; if (wlog_data[0] !== {4{32'hD200_0000}}) begin errors++; $display("FAIL co_wr_data: got %h want %h", wlog_data[0], {4{32'hD200_0000}}); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ed;
        clear_logs();
        mem_lat = 10;
        for (int k = 0; k < 5; k++) begin
            do_write(32'h0000_1000 + 32'(k * 16), {4{32'hF000_0000 + 32'(k)}});
            if (k == 3) begin
                checks++; if (wr_full_o !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b want 1", wr_full_o); end
            end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow_o); end
        wait_empty(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: got empty %0b want 1", empty_o); end
        checks++; if (wlog_addr.size() != 4) begin errors++; $display("FAIL ovf_wr_count: got %0d writes want 4", wlog_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < wlog_addr.size()) begin
                ea = 32'h0000_1000 + 32'(k * 16);
                ed = {4{32'hF000_0000 + 32'(k)}};
                checks++; if (wlog_addr[k] !== ea || wlog_data[k] !== ed) begin errors++; $display("FAIL ovf_order%0d: got %h/%h want %h/%h", k, wlog_addr[k], wlog_data[k], ea, ed); end
            end
        end
        checks++; if (overflow_o !== 1'b1 || wr_full_o !== 1'b0) begin errors++; $display("FAIL ovf_sticky: got ovf %0b full %0b want 1 0", overflow_o, wr_full_o); end
        mem_lat = 2;
        apply_reset();
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow_o); end
    endtask

    task automatic test_read_miss();
        bit ok;
        int t0;
        clear_logs();
        mem_lat = 5;
        mem_rd_val = {4{32'h3333_C0DE}};
        t0 = cyc;
        rd_req_i = 1'b1; rd_addr_i = 32'h0000_030C;
        tick();
        rd_req_i = 1'b0;
        checks++; if (mem_rd_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0300) begin errors++; $display("FAIL miss_req: got req %0b addr %h want 1 00000300", mem_rd_req_o, mem_addr_o); end
        wait_rd_rdy(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL miss_timeout: got rd_rdy %0b want 1", rd_rdy_o); end
        checks++; if (cyc - t0 != 7) begin errors++; $display("FAIL miss_latency: got %0d cycles want 7", cyc - t0); end
        checks++; if (rd_data_o !== {4{32'h3333_C0DE}}) begin errors++; $display("FAIL miss_data: got %h want %h", rd_data_o, {4{32'h3333_C0DE}}); end
        checks++; if (n_mem_rd !== 1) begin errors++; $display("FAIL miss_rd_count: got %0d want 1", n_mem_rd); end
    endtask

    task automatic test_rd_wait_write();
        bit ok;
        clear_logs();
        mem_lat = 5;
        mem_rd_val = {4{32'h4444_0000}};
        rd_req_i = 1'b1; rd_addr_i = 32'h0000_0400;
        tick();
        rd_req_i = 1'b0;
        checks++; if (mem_rd_req_o !== 1'b1) begin errors++; $display("FAIL rdw_req: got %0b want 1", mem_rd_req_o); end
        do_write(32'h0000_0404, {4{32'hD300_0400}});
        wait_rd_rdy(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rdw_timeout: got rd_rdy %0b want 1", rd_rdy_o); end
        checks++; if (rd_data_o !== {4{32'hD300_0400}}) begin errors++; $display("FAIL rdw_data: got %h want %h", rd_data_o, {4{32'hD300_0400}}); end
        tick();
        wait_empty(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rdw_drain: got empty %0b want 1", empty_o); end
        checks++; if (wlog_addr.size() != 1) begin errors++; $display("FAIL rdw_wr_count: got %0d writes want 1", wlog_addr.size()); end
        if (wlog_addr.size() > 0) begin
            checks++; if (wlog_addr[0] !== 32'h0000_0400 || wlog_data[0] !== {4{32'hD300_0400}}) begin errors++; $display("FAIL rdw_wr: got %h/%h want 00000400/%h", wlog_addr[0], wlog_data[0], {4{32'hD300_0400}}); end
        end
        mem_lat = 2;
    endtask

    initial begin : main
        test_reset();
        test_reset_mid_wr();
        test_forward();
        test_coalesce();
        test_overflow();
        test_read_miss();
        test_rd_wait_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
